// File: rtl/lcd_stream_rx.sv
// lcd_stream_rx: RGB LCD receiver recovering pixel x/y and locking onto the expected frame geometry.
// Optional LCD_RX_FRAME_CNT_EN adds a 16-bit count of good locked frames.
module lcd_stream_rx #(
  parameter int H_ACTIVE    = 480,
  parameter int V_ACTIVE    = 272,
  parameter int LOCK_FRAMES = 2,
  parameter int DATA_W      = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vid_de,
  input  logic              vid_hsync,
  input  logic              vid_vsync,
  input  logic [DATA_W-1:0] vid_data,
  output logic              pix_valid,
  output logic [11:0]       pix_x,
  output logic [9:0]        pix_y,
  output logic [DATA_W-1:0] pix_data,
  output logic              frame_start,
  output logic              locked,
`ifdef LCD_RX_FRAME_CNT_EN
  output logic              frame_err,
  output logic [15:0]       frame_cnt
`else
  output logic              frame_err
`endif
);
  localparam logic [11:0] H_A = 12'(H_ACTIVE);
  localparam logic [9:0]  V_A = 10'(V_ACTIVE);
  localparam logic [3:0]  L_F = 4'(LOCK_FRAMES);
  typedef enum logic [1:0] {SEARCH, CHECK, LOCK} state_t;
  state_t state, state_n;
  logic [3:0] good_cnt, good_cnt_n, inc;
  logic de1, hs1, vs1, de2, hs2, vs2;
  logic [DATA_W-1:0] data1;
  logic [11:0] x;
  logic [9:0] y;
  logic bad, good, err_n, pv;
  logic hs_fall, vs_fall, de_act, de_fall, de_rise;
  assign hs_fall = hs2 & ~hs1;
  assign vs_fall = vs2 & ~vs1;
  assign de_act  = de1 & vs1;
  assign de_fall = de2 & ~de1 & vs1;
  assign de_rise = de1 & ~de2 & vs1;
  assign good    = ~bad & (y == V_A);
  assign inc     = good_cnt + 4'd1;
  assign pv      = locked & de_act & (x < H_A) & (y < V_A);
  assign frame_start = pix_valid & (pix_x == 12'd0) & (pix_y == 10'd0);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      {de1, hs1, vs1, de2, hs2, vs2} <= '0;
      data1 <= '0;
    end else begin
      {de1, hs1, vs1} <= {vid_de, vid_hsync, vid_vsync};
      {de2, hs2, vs2} <= {de1, hs1, vs1};
      data1 <= vid_data;
    end
  // x/y saturate so a runaway line or frame can never alias back into range
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      x   <= '0;
      y   <= '0;
      bad <= 1'b0;
    end else begin
      if (hs_fall) x <= '0;
      else if (de_act && x != '1) x <= x + 12'd1;
      if (vs_fall) begin
        y   <= '0;
        bad <= 1'b0;
      end else begin
        if (de_fall && y != '1) y <= y + 10'd1;
        if ((de_fall && x != H_A) || (de_rise && x >= H_A)) bad <= 1'b1;
      end
    end
  always_comb begin
    state_n    = state;
    good_cnt_n = good_cnt;
    err_n      = 1'b0;
    if (vs_fall)
      case (state)
        SEARCH: begin
          state_n    = CHECK;
          good_cnt_n = '0;
        end
        CHECK: begin
          good_cnt_n = good ? inc : 4'd0;
          err_n      = ~good;
          state_n    = (good && inc >= L_F) ? LOCK : CHECK;
        end
        default: begin
          good_cnt_n = '0;
          err_n      = ~good;
          state_n    = good ? LOCK : CHECK;
        end
      endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= SEARCH;
      good_cnt  <= '0;
      locked    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      good_cnt  <= good_cnt_n;
      locked    <= state_n == LOCK;
      frame_err <= err_n;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_data  <= '0;
    end else begin
      pix_valid <= pv;
      if (pv) begin
        pix_x    <= x;
        pix_y    <= y;
        pix_data <= data1;
      end
    end
`ifdef LCD_RX_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) frame_cnt <= '0;
    else if (vs_fall && state == LOCK) frame_cnt <= good ? frame_cnt + 16'd1 : 16'd0;
`endif
endmodule

// File: tb/tb_lcd_stream_rx.sv
// tb_lcd_stream_rx: table-driven frame scenarios plus latency and mid-frame reset sequences.
module tb_lcd_stream_rx;
  localparam int H = 8, V = 4, DW = 24;
  logic clk = 1'b0, rst = 1'b0, de = 1'b0, hs = 1'b1, vs = 1'b1;
  logic [DW-1:0] data = '0;
  logic pix_valid, frame_start, locked, frame_err;
  logic [11:0] pix_x;
  logic [9:0] pix_y;
  logic [DW-1:0] pix_data;
`ifdef LCD_RX_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif
  int checks = 0, failures = 0, pix_cnt = 0, fs_cnt = 0, err_cnt = 0;
  bit exp_lock = 1'b0;
  logic [21:0] q[$];

  lcd_stream_rx #(.H_ACTIVE(H), .V_ACTIVE(V), .LOCK_FRAMES(2), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .vid_de(de), .vid_hsync(hs), .vid_vsync(vs), .vid_data(data),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
    .frame_start(frame_start), .locked(locked),
`ifdef LCD_RX_FRAME_CNT_EN
    .frame_err(frame_err), .frame_cnt(frame_cnt)
`else
    .frame_err(frame_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int lines, ml, mlen;
    bit mnohs, lk;
    int err, pix, fs, fc;
  } row_t;

  function automatic logic [DW-1:0] pat(int yy, int xx);
    return {2'b0, 10'(yy), 12'(xx)} ^ 24'h5A5A5A;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    if (frame_start) fs_cnt++;
    if (frame_err) err_cnt++;
    if (pix_valid) begin
      pix_cnt++;
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pix_unexpected: got x=%0d y=%0d expected no pixel", pix_x, pix_y);
      end else begin
        logic [21:0] e;
        e = q.pop_front();
        chk("pix_x", pix_x, e[11:0]);
        chk("pix_y", pix_y, e[21:12]);
        chk("pix_data", pix_data, pat(e[21:12], e[11:0]));
        chk("frame_start", frame_start, e == 22'd0);
      end
    end
  end

  task automatic line(int yy, int len, bit nohs);
    hs = nohs;
    @(negedge clk);
    hs = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < len; i++) begin
      de = 1'b1;
      data = pat(yy, i);
      if (exp_lock && !nohs && i < H && yy < V) q.push_back({10'(yy), 12'(i)});
      @(negedge clk);
    end
    de = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic vsync_pulse();
    vs = 1'b0;
    repeat (2) @(negedge clk);
    vs = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic frame(int lines, int ml, int mlen, bit mnohs);
    for (int l = 0; l < lines; l++) line(l, l == ml ? mlen : H, l == ml && mnohs);
    vsync_pulse();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at 1ms, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    row_t tbl[19];
    int pc, fc, ec;
    tbl = '{
      '{4, -1, 8, 0, 0, 0,  0, 0, 0},
      '{4, -1, 8, 0, 0, 0,  0, 0, 0},
      '{4, -1, 8, 0, 1, 0,  0, 0, 0},
      '{4, -1, 8, 0, 1, 0, 32, 1, 1},
      '{4, -1, 8, 0, 1, 0, 32, 1, 2},
      '{4,  1, 7, 0, 0, 1, 31, 1, 0},
      '{4, -1, 8, 0, 0, 0,  0, 0, 0},
      '{4, -1, 8, 0, 1, 0,  0, 0, 0},
      '{3, -1, 8, 0, 0, 1, 24, 1, 0},
      '{3, -1, 8, 0, 0, 1,  0, 0, 0},
      '{3, -1, 8, 0, 0, 1,  0, 0, 0},
      '{4, -1, 8, 0, 0, 0,  0, 0, 0},
      '{4, -1, 8, 0, 1, 0,  0, 0, 0},
      '{4,  2, 9, 0, 0, 1, 32, 1, 0},
      '{4, -1, 8, 0, 0, 0,  0, 0, 0},
      '{4, -1, 8, 0, 1, 0,  0, 0, 0},
      '{4,  1, 8, 1, 0, 1, 24, 1, 0},
      '{4, -1, 8, 0, 0, 0,  0, 0, 0},
      '{4, -1, 8, 0, 1, 0,  0, 0, 0}
    };
    repeat (3) @(negedge clk);
    chk("rst_locked", locked, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_pix_x", pix_x, 0);
    chk("rst_pix_data", pix_data, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int r = 0; r < 19; r++) begin
      pc = pix_cnt;
      fc = fs_cnt;
      ec = err_cnt;
      exp_lock = (r == 0) ? 1'b0 : tbl[r-1].lk;
      frame(tbl[r].lines, tbl[r].ml, tbl[r].mlen, tbl[r].mnohs);
      chk($sformatf("row%0d_locked", r), locked, tbl[r].lk);
      chk($sformatf("row%0d_frame_err", r), err_cnt - ec, tbl[r].err);
      chk($sformatf("row%0d_pix_count", r), pix_cnt - pc, tbl[r].pix);
      chk($sformatf("row%0d_frame_start", r), fs_cnt - fc, tbl[r].fs);
      chk($sformatf("row%0d_pix_missing", r), q.size(), 0);
`ifdef LCD_RX_FRAME_CNT_EN
      chk($sformatf("row%0d_frame_cnt", r), frame_cnt, tbl[r].fc);
`endif
    end
    // two-clock latency from vid_de to pix_valid on the first pixel of a locked frame
    exp_lock = 1'b1;
    hs = 1'b0;
    @(negedge clk);
    hs = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < H; i++) begin
      de = 1'b1;
      data = pat(0, i);
      q.push_back({10'd0, 12'(i)});
      if (i < 2) begin
        @(posedge clk);
        #1;
        chk($sformatf("latency_cycle%0d", i + 1), pix_valid, i);
      end
      @(negedge clk);
    end
    de = 1'b0;
    repeat (2) @(negedge clk);
    for (int l = 1; l < V; l++) line(l, H, 1'b0);
    vsync_pulse();
    chk("latency_frame_locked", locked, 1);
    chk("latency_frame_missing", q.size(), 0);
    // reset in the middle of a locked frame
    line(0, H, 1'b0);
    line(1, H, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("midrst_locked", locked, 0);
    chk("midrst_pix_valid", pix_valid, 0);
    chk("midrst_pix_x", pix_x, 0);
    chk("midrst_pix_y", pix_y, 0);
    chk("midrst_pix_data", pix_data, 0);
    chk("midrst_frame_start", frame_start, 0);
    @(negedge clk);
    rst = 1'b1;
    exp_lock = 1'b0;
    ec = err_cnt;
    line(2, H, 1'b0);
    line(3, H, 1'b0);
    vsync_pulse();
    chk("relock_edge1", locked, 0);
    frame(V, -1, H, 1'b0);
    chk("relock_edge2", locked, 0);
    frame(V, -1, H, 1'b0);
    chk("relock_edge3", locked, 1);
    chk("relock_no_err", err_cnt - ec, 0);
    exp_lock = 1'b1;
    pc = pix_cnt;
    frame(V, -1, H, 1'b0);
    chk("relock_pix_count", pix_cnt - pc, H * V);
    chk("relock_missing", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
